fft_input_unpacker: RTL
=======================

// Module: fft_input_unpacker
// PURPOSE
// - Host-side front end of the FFT datapath; mirrors the output packer, data flows the other way.
// - Accepts a frame of SAMPLES samples as wide LINE_W-bit host lines and buffers the whole frame.
// - Streams the frame one SIZE-bit sample per cycle into the FFT core over a valid/ready handshake.
// - Single frame buffer: fill completely, then drain completely, then refill.
// PARAMETERS
// - SIZE     16    bits per sample (multiple of 8)
// - SAMPLES  2048  samples per frame (power of 2)
// - LINE_W   512   bits per host line (multiple of SIZE)
// - Derived: SPL = LINE_W/SIZE = 32 samples per line; LINES = SAMPLES/SPL = 64 lines per frame
// PORTS
// - clk           in   1                   rising-edge clock
// - rst           in   1                   synchronous, active-high reset
// - line_in       in   LINE_W              host line; sample k is line_in[SIZE*k+SIZE-1 : SIZE*k]
// - line_valid    in   1                   line_in valid
// - line_ready    out  1                   block accepts a line this cycle
// - sample_out    out  SIZE                sample to the FFT core (registered)
// - sample_idx    out  $clog2(SAMPLES)     frame position of sample_out
// - sample_valid  out  1                   sample_out/sample_idx valid
// - sample_ready  in   1                   FFT core accepts the sample
// - frame_last    out  1                   high with the final sample of a frame
// - busy          out  1                   high in DRAIN state
// BEHAVIOUR
// - Clock/reset: single clock clk; reset rst is synchronous and active-high.
// - Reset: state=FILL, line_cnt=0, rd_cnt=0; line_ready=1; sample_valid=0; frame_last=0; busy=0.
//   - sample_out and sample_idx reset to 0.
//   - Buffer contents are not cleared.
// - Reset mid-frame: a partial fill or drain is discarded and the block returns to FILL.
// - FILL state:
//   - line_ready=1.
//   - A line is accepted when line_valid && line_ready.
//   - Accepted line n writes buf[SPL*n + k] = sample k, for k = 0..SPL-1; line_cnt increments.
//   - Acceptance of line LINES-1 transitions to DRAIN; line_ready drops the next cycle.
// - DRAIN state:
//   - line_ready=0; busy=1.
//   - Output register pipeline, one entry deep; rd_cnt counts 0..SAMPLES-1.
//   - First sample_valid rises 1 cycle after entering DRAIN; fill-to-first-sample latency is 1 clk.
//   - Transfer occurs when sample_valid && sample_ready.
//   - While sample_valid=1 && sample_ready=0, sample_out, sample_idx and frame_last hold stable.
//   - Back-to-back transfers at 1 sample/clk when sample_ready is held high.
//   - frame_last=1 exactly when sample_idx = SAMPLES-1 and sample_valid=1.
// - Drain end:
//   - On transfer of the last sample: sample_valid=0 next cycle; line_cnt=0, rd_cnt=0; state=FILL.
//   - line_ready=1 that same next cycle.
//   - No overlap: no line is accepted while any sample of the current frame is pending.
// - Counters wrap only via the FSM; overflow beyond LINES or SAMPLES is unreachable.
// - line_valid in DRAIN is ignored; the line is not consumed because line_ready=0.
// - sample_ready is ignored while sample_valid=0.
// CONFIGURATION
// - BIT_REVERSE_EN defined:
//   - DRAIN reads buf[bitrev(rd_cnt)], with reversal over $clog2(SAMPLES) bits.
//   - sample_idx still reports rd_cnt.
//   - The FFT core receives bit-reversed input order.
// - BIT_REVERSE_EN undefined: DRAIN reads buf[rd_cnt] (natural order).
// - Handshake, latency and FSM are identical in both builds.
// TESTING
// - Reset, then 64 lines where sample k of line n = 32n+k, sample_ready=1:
//   - 2048 samples with sample_out=sample_idx=0..2047, one per clk.
//   - frame_last on 2047; line_ready back to 1 the next cycle.
// - Same frame with sample_ready toggling 1,0,1,0:
//   - No sample lost or duplicated; outputs stable while stalled.
// - line_valid held high during DRAIN: no extra line consumed.
//   - The next frame begins at line_cnt=0 only after frame_last transfers.
// - rst pulsed after 10 lines of fill, then one full fresh frame:
//   - Output equals the fresh frame only.
//   - sample_valid=0 and line_ready=1 in the cycle after rst.
// - rst pulsed during DRAIN at sample 500: sample_valid=0 next cycle; block back in FILL.
// - BIT_REVERSE_EN build, ramp frame: sample_out at sample_idx=1 is 1024; at sample_idx=3 is 1536.

Source files
------------

// File: rtl/fft_input_unpacker.sv
// fft_input_unpacker
//   Host-side front end of the FFT datapath. Collects one frame of SAMPLES
//   samples, delivered as LINE_W-bit host lines. The whole frame is held in a
//   single buffer. The frame is then streamed to the FFT core, one SIZE-bit
//   sample per clock, over a valid/ready handshake. The buffer is filled
//   completely, drained completely, and only then refilled.
//
//   Optional build macro:
//     BIT_REVERSE_EN - the drain reads the buffer in bit-reversed address
//                      order. sample_idx still reports the natural drain count.
//
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   synchronous, active-high reset
//     line_in      in   host line; sample k is line_in[SIZE*k +: SIZE]
//     line_valid   in   line_in valid
//     line_ready   out  a line is accepted this cycle (FILL state)
//     sample_out   out  registered sample to the FFT core
//     sample_idx   out  frame position of sample_out
//     sample_valid out  sample_out / sample_idx valid
//     sample_ready in   FFT core accepts the sample
//     frame_last   out  high with the final sample of the frame
//     busy         out  high while draining
module fft_input_unpacker #(
  parameter int SIZE    = 16,
  parameter int SAMPLES = 2048,
  parameter int LINE_W  = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LINE_W-1:0]          line_in,
  input  logic                       line_valid,
  output logic                       line_ready,
  output logic [SIZE-1:0]            sample_out,
  output logic [$clog2(SAMPLES)-1:0] sample_idx,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       frame_last,
  output logic                       busy
);

  localparam int SPL   = LINE_W / SIZE;
  localparam int LINES = SAMPLES / SPL;
  localparam int AW    = $clog2(SAMPLES);
  localparam int SW    = $clog2(SPL);
  localparam int LW    = $clog2(LINES);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t            state;
  logic [LW-1:0]     line_cnt;
  logic [AW-1:0]     rd_cnt;

  // Frame buffer stored one host line per word; samples are picked out on read.
  logic [LINE_W-1:0] mem [LINES];

  logic              accept;
  logic              load;
  logic              last_xfer;
  logic [AW-1:0]     rd_addr;
  logic [LINE_W-1:0] rd_line;
  logic [SIZE-1:0]   rd_sample;

`ifdef BIT_REVERSE_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  assign rd_addr = bitrev(rd_cnt);
`else
  assign rd_addr = rd_cnt;
`endif

  assign accept    = line_valid && line_ready;
  // Load the output register when it is empty (first cycle of DRAIN) or when
  // the held sample is taken and it is not the last sample of the frame.
  assign load      = (state == S_DRAIN) && (!sample_valid || (sample_ready && !frame_last));
  assign last_xfer = sample_valid && sample_ready && frame_last;

  assign rd_line   = mem[rd_addr[AW-1:SW]];
  assign rd_sample = rd_line[rd_addr[SW-1:0]*SIZE +: SIZE];

  // Buffer write stage: the contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) mem[line_cnt] <= line_in;
  end

  // Control FSM and output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FILL;
      line_cnt     <= '0;
      rd_cnt       <= '0;
      line_ready   <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      frame_last   <= 1'b0;
      sample_out   <= '0;
      sample_idx   <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            line_cnt <= line_cnt + 1'b1;
            if (line_cnt == LW'(LINES - 1)) begin
              state      <= S_DRAIN;
              line_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (last_xfer) begin
            state        <= S_FILL;
            sample_valid <= 1'b0;
            frame_last   <= 1'b0;
            line_ready   <= 1'b1;
            busy         <= 1'b0;
            rd_cnt       <= '0;
            line_cnt     <= '0;
          end else if (load) begin
            sample_out   <= rd_sample;
            sample_idx   <= rd_cnt;
            frame_last   <= (rd_cnt == AW'(SAMPLES - 1));
            sample_valid <= 1'b1;
            rd_cnt       <= rd_cnt + 1'b1;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule
